// File: rtl/mont_pkg.sv
// Shared constants, FSM state type and sizing helper for the Montgomery datapath.
package mont_pkg;

  localparam int unsigned MONT_WIDTH = 1024;
  localparam int unsigned MONT_LIMB  = 128;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    SEL  = 2'd2
  } state_t;

  // Width of a limb index; never below one bit so single-limb builds stay legal.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/limb_sub.sv
// One LIMB-bit slice of the ripple subtractor: a - b - bin with borrow out.
module limb_sub #(
  parameter int unsigned LIMB = mont_pkg::MONT_LIMB
) (
  input  logic [LIMB-1:0] a,
  input  logic [LIMB-1:0] b,
  input  logic            bin,
  output logic [LIMB-1:0] diff_c,
  output logic            bout_c
);

  logic [LIMB:0] full;

  // The extra top bit goes high exactly when the slice underflows.
  always_comb begin
    full   = {1'b0, a} - {1'b0, b} - (LIMB+1)'(bin);
    diff_c = full[LIMB-1:0];
    bout_c = full[LIMB];
  end

endmodule

// File: rtl/mod_cond_sub.sv
// Conditional subtract of the modulus from the doubled value, one limb per cycle,
// giving x mod M for x < 2M with a start/busy/done handshake.
module mod_cond_sub
  import mont_pkg::*;
#(
  parameter int unsigned WIDTH = MONT_WIDTH,
  parameter int unsigned LIMB  = MONT_LIMB
) (
  input  logic             clk,
  input  logic             restn,
  input  logic             start,
  input  logic [WIDTH:0]   in_x,
  input  logic [WIDTH-1:0] in_m,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             subtracted
);

  localparam int unsigned NLIMB = WIDTH / LIMB;
  localparam int unsigned IDXW  = idx_width(NLIMB);
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NLIMB - 1);

  state_t           state;
  logic [WIDTH:0]   x_q;
  logic [WIDTH-1:0] m_q;
  logic [WIDTH-1:0] diff_q;
  logic             borrow_q;
  logic [IDXW-1:0]  idx_q;

  logic [LIMB-1:0]  a_c;
  logic [LIMB-1:0]  b_c;
  logic [LIMB-1:0]  d_c;
  logic             bout_c;
  logic             sub_c;

  // Route the current limb of both operands to the shared slice subtractor.
  always_comb begin
    a_c = '0;
    b_c = '0;
    for (int unsigned i = 0; i < NLIMB; i++) begin
      if (idx_q == IDXW'(i)) begin
        a_c = x_q[i*LIMB +: LIMB];
        b_c = m_q[i*LIMB +: LIMB];
      end
    end
  end

  limb_sub #(
    .LIMB (LIMB)
  ) u_limb_sub (
    .a      (a_c),
    .b      (b_c),
    .bin    (borrow_q),
    .diff_c (d_c),
    .bout_c (bout_c)
  );

  // x[WIDTH] alone means x exceeds any modulus, so the final borrow is irrelevant then.
  assign sub_c = x_q[WIDTH] | ~borrow_q;

  always_ff @(posedge clk or negedge restn) begin
    if (!restn) begin
      state      <= IDLE;
      x_q        <= '0;
      m_q        <= '0;
      diff_q     <= '0;
      borrow_q   <= 1'b0;
      idx_q      <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      result     <= '0;
      subtracted <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            x_q      <= in_x;
            m_q      <= in_m;
            borrow_q <= 1'b0;
            idx_q    <= '0;
            busy     <= 1'b1;
            state    <= RUN;
          end
        end
        RUN: begin
          for (int unsigned i = 0; i < NLIMB; i++) begin
            if (idx_q == IDXW'(i)) begin
              diff_q[i*LIMB +: LIMB] <= d_c;
            end
          end
          borrow_q <= bout_c;
          idx_q    <= idx_q + 1'b1;
          if (idx_q == LAST_IDX) begin
            state <= SEL;
          end
        end
        SEL: begin
          result     <= sub_c ? diff_q : x_q[WIDTH-1:0];
          subtracted <= sub_c;
          done       <= 1'b1;
          busy       <= 1'b0;
          state      <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
